// File: rtl/safety_island_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : safety_island_boot_ctrl
// Description : Boot sequencer for the safety-island core. Holds the core in
//               reset for a fixed number of cycles, samples the boot mode
//               once, waits for the matching boot trigger (debugger fetch
//               enable or host preload-done), then releases fetch with the
//               selected entry address. Invalid mode or trigger timeout
//               parks the core in reset with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module safety_island_boot_ctrl #(
    parameter logic [31:0] BootRomAddr   = 32'h0000_1000,
    parameter int unsigned RstHoldCycles = 8,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  bootmode_i,
    input  logic        fetch_en_reg_i,
    input  logic        preload_done_i,
    input  logic [31:0] boot_addr_reg_i,
    input  logic        soft_rst_i,
    output logic        core_rst_o,
    output logic        fetch_en_o,
    output logic [31:0] boot_addr_o,
    output logic [2:0]  state_o,
    output logic        error_o
);

    // Counter widths leave one spare bit so the last count value always fits
    localparam int unsigned C_HOLD_W = $clog2(RstHoldCycles) + 1;
    localparam int unsigned C_WAIT_W = $clog2(TimeoutCycles) + 1;

    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(RstHoldCycles - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_ONE  = C_HOLD_W'(1);

    // With the timeout disabled the compare value is irrelevant; keep it legal
    localparam int unsigned         C_WAIT_LAST_INT = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
    localparam logic [C_WAIT_W-1:0] C_WAIT_LAST     = C_WAIT_W'(C_WAIT_LAST_INT);
    localparam logic [C_WAIT_W-1:0] C_WAIT_ONE      = C_WAIT_W'(1);
    localparam logic                C_TIMEOUT_EN    = (TimeoutCycles != 0);

    typedef enum logic [2:0] {
        RST_HOLD     = 3'd0,
        WAIT_JTAG    = 3'd1,
        WAIT_PRELOAD = 3'd2,
        BOOT         = 3'd3,
        ERROR        = 3'd4
    } state_t;

    state_t              r_state;
    logic [C_HOLD_W-1:0] r_hold_cnt;
    logic [C_WAIT_W-1:0] r_wait_cnt;
    logic                r_core_rst;
    logic                r_fetch_en;
    logic [31:0]         r_boot_addr;
    logic                r_error;

    logic                w_hold_done;
    logic                w_timeout_hit;

    assign w_hold_done   = (r_hold_cnt == C_HOLD_LAST);
    assign w_timeout_hit = C_TIMEOUT_EN && (r_wait_cnt == C_WAIT_LAST);

    // Boot sequencer: state, counters and all registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= RST_HOLD;
            r_hold_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_core_rst  <= 1'b1;
            r_fetch_en  <= 1'b0;
            r_boot_addr <= BootRomAddr;
            r_error     <= 1'b0;
        end else if (soft_rst_i) begin
            // Re-boot request overrides everything and restarts the hold
            r_state    <= RST_HOLD;
            r_hold_cnt <= '0;
            r_wait_cnt <= '0;
            r_core_rst <= 1'b1;
            r_fetch_en <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                RST_HOLD: begin
                    if (w_hold_done) begin
                        // Boot mode is sampled exactly once, here
                        r_hold_cnt <= '0;
                        r_wait_cnt <= '0;
                        case (bootmode_i)
                            2'b00: begin
                                r_state    <= WAIT_JTAG;
                                r_core_rst <= 1'b0;
                            end
                            2'b01: begin
                                r_state    <= WAIT_PRELOAD;
                                r_core_rst <= 1'b0;
                            end
                            default: begin
                                r_state    <= ERROR;
                                r_core_rst <= 1'b1;
                                r_error    <= 1'b1;
                            end
                        endcase
                    end else if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + C_HOLD_ONE;
                    end
                end

                WAIT_JTAG, WAIT_PRELOAD: begin
                    // A trigger wins over a coincident timeout
                    if ((r_state == WAIT_JTAG) ? fetch_en_reg_i : preload_done_i) begin
                        r_state     <= BOOT;
                        r_fetch_en  <= 1'b1;
                        r_boot_addr <= (r_state == WAIT_JTAG) ? BootRomAddr : boot_addr_reg_i;
                    end else if (w_timeout_hit) begin
                        r_state    <= ERROR;
                        r_core_rst <= 1'b1;
                        r_error    <= 1'b1;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + C_WAIT_ONE;
                    end
                end

                BOOT: begin
                    // Terminal until reset: outputs are frozen
                    r_fetch_en <= 1'b1;
                end

                ERROR: begin
                    r_core_rst <= 1'b1;
                    r_fetch_en <= 1'b0;
                    r_error    <= 1'b1;
                end

                default: begin
                    r_state    <= RST_HOLD;
                    r_hold_cnt <= '0;
                    r_wait_cnt <= '0;
                    r_core_rst <= 1'b1;
                    r_fetch_en <= 1'b0;
                    r_error    <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_o  = r_core_rst;
    assign fetch_en_o  = r_fetch_en;
    assign boot_addr_o = r_boot_addr;
    assign state_o     = r_state;
    assign error_o     = r_error;

endmodule
`default_nettype wire

// File: doc/safety_island_boot_ctrl.md
SAFETY_ISLAND_BOOT_CTRL -- requirements
Module: safety_island_boot_ctrl

Interface
REQ-001 SHALL have parameter BootRomAddr, default 32'h0000_1000, meaning the entry address for Jtag boot (boot ROM base).
REQ-002 SHALL have parameter RstHoldCycles, default 8, meaning the number of cycles the core reset is held after reset or soft reset (range 1..255).
REQ-003 SHALL have parameter TimeoutCycles, default 1024, meaning the maximum wait for a boot trigger; 0 disables the timeout.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port bootmode_i, input, 2 bits: 2'b00 Jtag, 2'b01 Preloaded, 2'b1x invalid.
REQ-007 SHALL have port fetch_en_reg_i, input, 1 bit: fetch-enable bit from SoC control, set by the debugger.
REQ-008 SHALL have port preload_done_i, input, 1 bit: host pulse/level signalling that the preload is complete.
REQ-009 SHALL have port boot_addr_reg_i, input, 32 bits: entry address from SoC control for Preloaded boot.
REQ-010 SHALL have port soft_rst_i, input, 1 bit: synchronous re-boot request.
REQ-011 SHALL have port core_rst_o, output, 1 bit: active-high core reset.
REQ-012 SHALL have port fetch_en_o, output, 1 bit: core fetch enable.
REQ-013 SHALL have port boot_addr_o, output, 32 bits: core boot address.
REQ-014 SHALL have port state_o, output, 3 bits: FSM state encoding for status readback.
REQ-015 SHALL have port error_o, output, 1 bit: boot error flag.

Function
REQ-016 SHALL implement the FSM states RST_HOLD=3'd0, WAIT_JTAG=3'd1, WAIT_PRELOAD=3'd2, BOOT=3'd3, ERROR=3'd4, driven on state_o.
REQ-017 In RST_HOLD, SHALL assert core_rst_o=1 and fetch_en_o=0, and count RstHoldCycles cycles, then sample bootmode_i once.
REQ-018 On exit from RST_HOLD, SHALL go to WAIT_JTAG for 2'b00, WAIT_PRELOAD for 2'b01, and ERROR for 2'b1x.
REQ-019 In WAIT_* states, SHALL deassert core_rst_o and keep fetch_en_o=0; bootmode_i changes are ignored.
REQ-020 WAIT_JTAG SHALL go to BOOT on the first cycle fetch_en_reg_i=1, with boot_addr_o <= BootRomAddr.
REQ-021 WAIT_PRELOAD SHALL go to BOOT on the first cycle preload_done_i=1, with boot_addr_o <= boot_addr_reg_i sampled in that cycle; a 1-cycle pulse suffices.
REQ-022 A wait counter SHALL start at 0 on WAIT_* entry and increment each WAIT cycle; with TimeoutCycles≠0 and the counter reaching TimeoutCycles-1 with no trigger, the next state SHALL be ERROR.
REQ-023 A trigger in the same cycle as the timeout SHALL take precedence, and the FSM goes to BOOT.
REQ-024 In BOOT, SHALL hold fetch_en_o=1 and boot_addr_o stable; later changes to fetch_en_reg_i, preload_done_i and boot_addr_reg_i SHALL have no effect.
REQ-025 In ERROR, SHALL hold core_rst_o=1, fetch_en_o=0 and error_o=1; error_o SHALL be 0 in all other states.
REQ-026 soft_rst_i=1 in any state SHALL force next state RST_HOLD, restart the hold counter, clear the wait counter and clear fetch_en_o the following cycle; soft_rst_i SHALL take priority over all other transitions.
REQ-027 soft_rst_i held high SHALL keep the FSM in RST_HOLD; counting starts after soft_rst_i is released.
REQ-028 All outputs SHALL be registered, with a latency of 1 cycle from trigger to fetch_en_o=1.
REQ-029 The counters SHALL be sized to clog2 of their parameter plus 1 and SHALL saturate rather than wrap.

Reset
REQ-030 While rst_i=1, SHALL hold state=RST_HOLD, core_rst_o=1, fetch_en_o=0, boot_addr_o=BootRomAddr, error_o=0, and both counters at 0.
REQ-031 Assertion of rst_i mid-BOOT SHALL drop fetch_en_o asynchronously in the same cycle.
REQ-032 After rst_i deasserts, the first rising edge SHALL begin the hold count.

Verification
REQ-033 Jtag boot: bootmode=00, release rst, fetch_en_reg_i=1 at cycle 20 -> core_rst_o=0 from cycle 9, fetch_en_o=1 at cycle 21, boot_addr_o=32'h0000_1000.
REQ-034 Preloaded boot: bootmode=01, boot_addr_reg_i=32'h1000_0080, 1-cycle preload_done_i -> BOOT reached, boot_addr_o=32'h1000_0080, unchanged after boot_addr_reg_i changes.
REQ-035 Timeout: bootmode=01, no trigger, TimeoutCycles=16 -> ERROR exactly 16 WAIT cycles after entry, error_o=1, core_rst_o=1; trigger coincident with the final count -> BOOT instead.
REQ-036 Invalid mode: bootmode=2'b11 -> ERROR directly after RST_HOLD; soft_rst_i pulse with bootmode=00 -> RST_HOLD, then WAIT_JTAG, error_o=0.
REQ-037 Soft reset from BOOT: soft_rst_i in BOOT -> fetch_en_o=0 and core_rst_o=1 next cycle, full RstHoldCycles hold repeated.
REQ-038 Async reset mid-WAIT: rst_i asserted between edges -> outputs at reset values before the next edge.
